// File: rtl/snn_dec_pkg.sv
// Shared types and helpers for the spike window decoder: FSM encoding,
// derived width helpers and the saturating increment.
package snn_dec_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } dec_state_t;

  // Window counter must be able to hold WINDOW_CYCLES itself.
  function automatic int win_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  function automatic int idx_width(input int n_ch);
    return (n_ch < 2) ? 1 : $clog2(n_ch);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/spike_window_decoder_sat_counter.sv
// Per-channel saturating spike counter with synchronous clear and
// increment enable; clear wins over increment.
module spike_sat_counter
  import snn_dec_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [31:0] MAX_VALUE = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= CNT_W'(sat_inc(32'(count_reg), MAX_VALUE));
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/spike_window_decoder.sv
// Windowed spike-count readout: counts spikes per channel over a fixed window
// and latches counts, winner, tie and none. Optional macro SPIKE_DEC_FIRST_EN
// breaks count ties by earliest first spike in the window.
module spike_window_decoder
  import snn_dec_pkg::*;
#(
  parameter  int N_CH          = 2,
  parameter  int CNT_W         = 8,
  parameter  int WINDOW_CYCLES = 64,
  localparam int WIN_W         = win_width(WINDOW_CYCLES),
  localparam int IDX_W         = idx_width(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [N_CH-1:0]       spikes_in,
  output logic [N_CH*CNT_W-1:0] count_out,
  output logic [IDX_W-1:0]      winner,
  output logic                  tie,
  output logic                  none,
  output logic                  valid,
  output logic                  busy
);

  localparam logic [WIN_W-1:0] LAST_CYCLE = WIN_W'(WINDOW_CYCLES - 1);

  dec_state_t       state_reg, state_next;
  logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
  logic             counting;
  logic             clear_live;

  logic [CNT_W-1:0]      live [N_CH];
  logic [N_CH*CNT_W-1:0] live_flat;

  logic [N_CH*CNT_W-1:0] count_out_reg;
  logic [IDX_W-1:0]      winner_reg, winner_next;
  logic                  tie_reg, tie_next;
  logic                  none_reg, none_next;
  logic                  valid_reg;
  logic                  busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      win_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      win_cnt_reg <= win_cnt_next;
    end
  end

  // Dropping run mid-window aborts; the same clear path as REPORT empties counters.
  always_comb begin
    state_next   = state_reg;
    win_cnt_next = win_cnt_reg;
    clear_live   = 1'b0;
    counting     = 1'b0;
    case (state_reg)
      IDLE: begin
        clear_live   = 1'b1;
        win_cnt_next = '0;
        if (run) state_next = COUNT;
      end
      COUNT: begin
        if (!run) begin
          state_next   = IDLE;
          clear_live   = 1'b1;
          win_cnt_next = '0;
        end else begin
          counting     = 1'b1;
          win_cnt_next = win_cnt_reg + WIN_W'(1);
          if (win_cnt_reg == LAST_CYCLE) state_next = REPORT;
        end
      end
      REPORT: begin
        clear_live   = 1'b1;
        win_cnt_next = '0;
        state_next   = run ? COUNT : IDLE;
      end
      default: begin
        state_next   = IDLE;
        clear_live   = 1'b1;
        win_cnt_next = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      spike_sat_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_live),
        .inc   (counting & spikes_in[gi]),
        .count (live[gi])
      );
      assign live_flat[gi*CNT_W +: CNT_W] = live[gi];
    end
  endgenerate

`ifdef SPIKE_DEC_FIRST_EN
  logic [WIN_W-1:0] first_reg [N_CH];
  logic             seen_reg  [N_CH];

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          first_reg[gi] <= '0;
          seen_reg[gi]  <= 1'b0;
        end else if (clear_live) begin
          first_reg[gi] <= '0;
          seen_reg[gi]  <= 1'b0;
        end else if (counting && spikes_in[gi] && !seen_reg[gi]) begin
          first_reg[gi] <= win_cnt_reg;
          seen_reg[gi]  <= 1'b1;
        end
      end
    end
  endgenerate
`endif

  logic [CNT_W-1:0] best_cnt;
  logic             hit;
`ifdef SPIKE_DEC_FIRST_EN
  logic [WIN_W-1:0] best_first;
`endif

  // A nonzero count implies the channel was seen, so its timestamp is valid.
  always_comb begin
    winner_next = '0;
    best_cnt    = live[0];
`ifdef SPIKE_DEC_FIRST_EN
    best_first  = first_reg[0];
`endif
    for (int i = 1; i < N_CH; i++) begin
      if (live[i] > best_cnt) begin
        winner_next = IDX_W'(i);
        best_cnt    = live[i];
`ifdef SPIKE_DEC_FIRST_EN
        best_first  = first_reg[i];
      end else if (live[i] == best_cnt && live[i] != '0 &&
                   first_reg[i] < best_first) begin
        winner_next = IDX_W'(i);
        best_first  = first_reg[i];
`endif
      end
    end
    tie_next = 1'b0;
    hit      = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (live[i] == best_cnt && best_cnt != '0) begin
        if (hit) tie_next = 1'b1;
        hit = 1'b1;
      end
    end
    none_next = (best_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out_reg <= '0;
      winner_reg    <= '0;
      tie_reg       <= 1'b0;
      none_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      valid_reg <= (state_reg == REPORT);
      busy_reg  <= (state_next != IDLE);
      if (state_reg == REPORT) begin
        count_out_reg <= live_flat;
        winner_reg    <= winner_next;
        tie_reg       <= tie_next;
        none_reg      <= none_next;
      end
    end
  end

  assign count_out = count_out_reg;
  assign winner    = winner_reg;
  assign tie       = tie_reg;
  assign none      = none_reg;
  assign valid     = valid_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed bench: two decoder instances (8-cycle window / 20-cycle window with
// 4-bit counters), checked with immediate assertions at each step.
module tb_spike_window_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        run_a = 1'b0;
  logic [1:0]  spikes_a = 2'b00;
  logic [15:0] count_a;
  logic        winner_a, tie_a, none_a, valid_a, busy_a;

  logic        run_b = 1'b0;
  logic [1:0]  spikes_b = 2'b00;
  logic [7:0]  count_b;
  logic        winner_b, tie_b, none_b, valid_b, busy_b;

`ifdef SPIKE_DEC_FIRST_EN
  localparam logic [31:0] TIE_WIN = 32'd1;
`else
  localparam logic [31:0] TIE_WIN = 32'd0;
`endif

  spike_window_decoder #(.N_CH(2), .CNT_W(8), .WINDOW_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run_a), .spikes_in(spikes_a),
    .count_out(count_a), .winner(winner_a), .tie(tie_a), .none(none_a),
    .valid(valid_a), .busy(busy_a)
  );

  spike_window_decoder #(.N_CH(2), .CNT_W(4), .WINDOW_CYCLES(20)) dut_sat (
    .clk(clk), .rst_n(rst_n), .run(run_b), .spikes_in(spikes_b),
    .count_out(count_b), .winner(winner_b), .tie(tie_b), .none(none_b),
    .valid(valid_b), .busy(busy_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int valid_cnt = 0;
  int valid_cyc [$];
  int last_edge = 0;
  logic found;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives the 8 counted cycles; returns at the negedge inside REPORT.
  task automatic feed(input logic [7:0] p0, input logic [7:0] p1);
    for (int c = 0; c < 8; c++) begin
      spikes_a = {p1[c], p0[c]};
      @(negedge clk);
    end
    last_edge = cyc;
    spikes_a  = 2'b11;
    chk("report_busy", 32'(busy_a), 32'd1);
    chk("report_no_valid", 32'(valid_a), 32'd0);
  endtask

  task automatic check_report(input string tag, input int c0, input int c1,
                              input int w, input int t, input int n);
    $display("[TB] %s: count0=%0d count1=%0d winner=%0d tie=%0d none=%0d valid=%0d",
             tag, count_a[7:0], count_a[15:8], winner_a, tie_a, none_a, valid_a);
    chk({tag, "_valid"}, 32'(valid_a), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(last_edge + 1));
    chk({tag, "_count0"}, 32'(count_a[7:0]), 32'(c0));
    chk({tag, "_count1"}, 32'(count_a[15:8]), 32'(c1));
    chk({tag, "_winner"}, 32'(winner_a), 32'(w));
    chk({tag, "_tie"}, 32'(tie_a), 32'(t));
    chk({tag, "_none"}, 32'(none_a), 32'(n));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_winner", 32'(winner_a), 32'd0);
    chk("rst_tie", 32'(tie_a), 32'd0);
    chk("rst_none", 32'(none_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("idle_valid", 32'(valid_a), 32'd0);

    // basic: ch0 3 spikes, ch1 5 spikes
    run_a = 1'b1;
    @(negedge clk);
    chk("start_busy", 32'(busy_a), 32'd1);
    feed(8'b0010_0101, 8'b1101_1010);
    run_a = 1'b0;
    @(negedge clk);
    check_report("basic", 3, 5, 1, 0, 0);
    @(negedge clk);
    chk("basic_pulse_end", 32'(valid_a), 32'd0);
    chk("basic_busy_end", 32'(busy_a), 32'd0);

    // all-zero window
    run_a = 1'b1;
    @(negedge clk);
    feed(8'h00, 8'h00);
    run_a = 1'b0;
    @(negedge clk);
    check_report("none", 0, 0, 0, 0, 1);
    @(negedge clk);

    // tie, ch1 spikes first
    run_a = 1'b1;
    @(negedge clk);
    feed(8'hF0, 8'h0F);
    run_a = 1'b0;
    @(negedge clk);
    check_report("tie", 4, 4, TIE_WIN, 1, 0);
    @(negedge clk);

    // abort at window cycle 4
    run_a = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      spikes_a = 2'b11;
      @(negedge clk);
    end
    run_a = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_valid", 32'(valid_a), 32'd0);
    spikes_a = 2'b00;
    repeat (12) @(negedge clk);
    $display("[TB] abort: count0=%0d count1=%0d winner=%0d valid_pulses=%0d",
             count_a[7:0], count_a[15:8], winner_a, valid_cnt);
    chk("abort_pulses", 32'(valid_cnt), 32'd3);
    chk("abort_held_count", 32'(count_a), 32'h0404);
    chk("abort_held_winner", 32'(winner_a), TIE_WIN);
    chk("abort_held_tie", 32'(tie_a), 32'd1);

    // three back-to-back windows
    run_a = 1'b1;
    @(negedge clk);
    feed(8'hFF, 8'h00);
    @(negedge clk);
    check_report("b2b1", 8, 0, 0, 0, 0);
    feed(8'h01, 8'h03);
    @(negedge clk);
    check_report("b2b2", 1, 2, 1, 0, 0);
    feed(8'h55, 8'h07);
    run_a = 1'b0;
    @(negedge clk);
    check_report("b2b3", 4, 3, 0, 0, 0);
    @(negedge clk);
    chk("b2b_busy_end", 32'(busy_a), 32'd0);
    chk("b2b_pulses", 32'(valid_cnt), 32'd6);
    if (valid_cyc.size() == 6) begin
      chk("b2b_space12", 32'(valid_cyc[4] - valid_cyc[3]), 32'd9);
      chk("b2b_space23", 32'(valid_cyc[5] - valid_cyc[4]), 32'd9);
    end else begin
      chk("b2b_pulse_log", 32'(valid_cyc.size()), 32'd6);
    end

    // saturation: 4-bit counter, 20-cycle window, ch0 always high
    run_b = 1'b1;
    spikes_b = 2'b01;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (valid_b === 1'b1) found = 1'b1;
    end
    $display("[TB] sat: count0=%0d count1=%0d winner=%0d valid=%0d",
             count_b[3:0], count_b[7:4], winner_b, found);
    chk("sat_valid_seen", 32'(found), 32'd1);
    chk("sat_count", 32'(count_b), 32'h0F);
    chk("sat_winner", 32'(winner_b), 32'd0);
    chk("sat_tie", 32'(tie_b), 32'd0);
    chk("sat_none", 32'(none_b), 32'd0);
    run_b = 1'b0;
    spikes_b = 2'b00;
    repeat (2) @(negedge clk);

    // asynchronous reset in the middle of a window
    run_a = 1'b1;
    @(negedge clk);
    spikes_a = 2'b01;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset: count=%0h busy=%0d valid=%0d", count_a, busy_a, valid_a);
    chk("arst_count", 32'(count_a), 32'd0);
    chk("arst_winner", 32'(winner_a), 32'd0);
    chk("arst_tie", 32'(tie_a), 32'd0);
    chk("arst_none", 32'(none_a), 32'd0);
    chk("arst_valid", 32'(valid_a), 32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_count_b", 32'(count_b), 32'd0);
    run_a = 1'b0;
    spikes_a = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy_a), 32'd0);
    chk("post_rst_valid", 32'(valid_a), 32'd0);
    chk("post_rst_pulses", 32'(valid_cnt), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
